// File: rtl/alu_uart_interface.sv
// Serial front end for an ALU: gathers A, B and OP bytes from a UART receiver,
// waits for the ALU result to settle, then hands the result byte to the transmitter.
module alu_uart_interface #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_OP   = 6,
  parameter int unsigned N_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic [N_BITS-1:0] i_alu_result,
  input  logic              i_tx_done,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_OP-1:0]   o_OP,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    WaitA,
    WaitB,
    WaitOp,
    AluWait,
    Send,
    WaitTx
  } state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   a_q, a_d;
  logic [N_BITS-1:0]   b_q, b_d;
  logic [N_OP-1:0]     op_q, op_d;
  logic [N_BITS-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rx_done_q;
  logic                accept;

  // Receiver may hold rx_done for several cycles; only its rising edge is a new byte.
  assign accept = i_rx_done & ~rx_done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WaitA;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      cnt_q      <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      cnt_q      <= cnt_d;
      rx_done_q  <= i_rx_done;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      WaitA: begin
        if (accept) begin
          a_d     = i_rx_data;
          state_d = WaitB;
        end
      end
      WaitB: begin
        if (accept) begin
          b_d     = i_rx_data;
          state_d = WaitOp;
        end
      end
      WaitOp: begin
        if (accept) begin
          op_d    = i_rx_data[N_OP-1:0];
          cnt_d   = '0;
          state_d = AluWait;
        end
      end
      AluWait: begin
        cnt_d = 4'(cnt_q + 4'd1);
        if (cnt_q == 4'(N_WAIT - 1)) state_d = Send;
      end
      Send: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WaitTx;
      end
      WaitTx: begin
        // Bytes arriving here are dropped; only tx_done matters.
        if (i_tx_done) state_d = WaitA;
      end
      default: state_d = WaitA;
    endcase
  end

  assign o_A        = a_q;
  assign o_B        = b_q;
  assign o_OP       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != WaitA);

endmodule
